// File: rtl/sorteio_pkg.sv
// sorteio_pkg: role codes, FSM state encoding and LFSR constants shared by the role-assignment engine.
package sorteio_pkg;
    localparam logic [1:0] PAPEL_ALDEAO  = 2'b00;
    localparam logic [1:0] PAPEL_LOBO    = 2'b01;
    localparam logic [1:0] PAPEL_MEDICO  = 2'b10;
    localparam logic [1:0] PAPEL_VIDENTE = 2'b11;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_INIT = 16'h0001;
    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        SORTEIA = 3'd1,
        PRONTO  = 3'd2
    } estado_t;
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ LFSR_TAPS) : {1'b0, s[15:1]};
    endfunction
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: 16-bit Galois LFSR with optional XOR mixing of external entropy; a zero result restarts from LFSR_INIT.
module lfsr_galois
    import sorteio_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] mix,
    input  logic        mix_valid,
    output logic [15:0] estado
);
    logic [15:0] prox;
    always_comb begin
        prox = en ? lfsr_step(estado) : estado;
        prox = mix_valid ? prox ^ mix : prox;
    end
    always_ff @(posedge clock) begin
        if (reset) estado <= LFSR_INIT;
        else       estado <= (prox == 16'h0) ? LFSR_INIT : prox;
    end
endmodule

// File: rtl/sorteador_papeis.sv
// sorteador_papeis: deals wolves, doctors and (with SORTEADOR_VIDENTE_EN defined) one seer to N_JOG players
// using an LFSR-driven placement FSM that falls back to the lowest free slot after MAX_TENT rejected draws.
module sorteador_papeis
    import sorteio_pkg::*;
#(
    parameter int N_JOG     = 5,
    parameter int N_LOBOS   = 1,
    parameter int N_MEDICOS = 1,
    parameter int MAX_TENT  = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               botao,
    input  logic               inicia,
    output logic [2*N_JOG-1:0] papeis,
    output logic               pronto,
    output logic               ocupado,
    output logic [15:0]        db_seed,
    output logic [2:0]         db_estado
);
`ifdef SORTEADOR_VIDENTE_EN
    localparam int N_VID = 1;
`else
    localparam int N_VID = 0;
`endif
    localparam int N_PAPEIS = N_LOBOS + N_MEDICOS + N_VID;
    localparam int IDX_W    = $clog2(N_JOG);

    if (N_PAPEIS > N_JOG || N_LOBOS < 1 || N_JOG < 2 || N_JOG > 16 || MAX_TENT < 1 || MAX_TENT > 255) begin : g_param_err
        $error("sorteador_papeis: invalid parameter combination");
    end

    estado_t     estado;
    logic [15:0] lfsr, ciclo;
    logic        botao_q;
    logic [4:0]  n_pap;
    logic [7:0]  tent;
    logic [3:0]  cand, livre, alvo;
    logic        cand_ok, fallback, grava;
    logic [1:0]  papel;

    lfsr_galois u_lfsr (
        .clock     (clock),
        .reset     (reset),
        .en        (1'b1),
        .mix       (ciclo),
        .mix_valid (botao & ~botao_q),
        .estado    (lfsr)
    );

    // Scanning from the top index down leaves livre at the lowest free player.
    always_comb begin
        cand    = 4'(lfsr[IDX_W-1:0]);
        livre   = '0;
        cand_ok = 1'b0;
        for (int i = N_JOG - 1; i >= 0; i--) begin
            if (papeis[2*(N_JOG-1-i) +: 2] == PAPEL_ALDEAO) begin
                livre   = 4'(i);
                cand_ok = cand_ok | (cand == 4'(i));
            end
        end
        fallback = tent == 8'(MAX_TENT);
        grava    = fallback | cand_ok;
        alvo     = fallback ? livre : cand;
        papel    = n_pap < 5'(N_LOBOS) ? PAPEL_LOBO :
                   n_pap < 5'(N_LOBOS + N_MEDICOS) ? PAPEL_MEDICO : PAPEL_VIDENTE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado  <= OCIOSO;
            papeis  <= '0;
            pronto  <= 1'b0;
            ocupado <= 1'b0;
            db_seed <= '0;
            n_pap   <= '0;
            tent    <= '0;
            ciclo   <= '0;
            botao_q <= 1'b0;
        end else begin
            ciclo   <= ciclo + 16'd1;
            botao_q <= botao;
            if (estado != SORTEIA && inicia) begin
                estado  <= SORTEIA;
                db_seed <= lfsr;
                papeis  <= '0;
                n_pap   <= '0;
                tent    <= '0;
                pronto  <= 1'b0;
                ocupado <= 1'b1;
            end else if (estado == SORTEIA) begin
                if (grava) begin
                    papeis[2*(N_JOG-1-int'(alvo)) +: 2] <= papel;
                    n_pap <= n_pap + 5'd1;
                    tent  <= '0;
                    if (n_pap == 5'(N_PAPEIS - 1)) begin
                        estado  <= PRONTO;
                        pronto  <= 1'b1;
                        ocupado <= 1'b0;
                    end
                end else begin
                    tent <= tent + 8'd1;
                end
            end
        end
    end

    assign db_estado = estado;
endmodule

// File: tb/tb_sorteador_papeis.sv
// tb_sorteador_papeis: directed checks of reset, timing, placement and entropy mixing for three engine configurations.
module tb_sorteador_papeis;
`ifdef SORTEADOR_VIDENTE_EN
    localparam int NV = 1, B_MED = 0;
`else
    localparam int NV = 0, B_MED = 1;
`endif
    logic clock = 1'b0, reset = 1'b1, botao = 1'b0;
    logic inicia_a = 1'b0, inicia_b = 1'b0, inicia_c = 1'b0;
    logic [9:0]  pap_a, pap_c;
    logic [3:0]  pap_b;
    logic        pronto_a, pronto_b, pronto_c, ocup_a, ocup_b, ocup_c;
    logic [15:0] seed_a, seed_b, seed_c;
    logic [2:0]  est_a, est_b, est_c;
    logic [15:0] ref_lfsr, ref_cnt;
    logic        ref_bq;
    int n_cmp = 0, n_err = 0;

    always #5 clock = ~clock;

    sorteador_papeis u_a (.clock(clock), .reset(reset), .botao(botao), .inicia(inicia_a), .papeis(pap_a),
        .pronto(pronto_a), .ocupado(ocup_a), .db_seed(seed_a), .db_estado(est_a));
    sorteador_papeis #(.N_JOG(2), .N_LOBOS(1), .N_MEDICOS(B_MED)) u_b (.clock(clock), .reset(reset), .botao(botao),
        .inicia(inicia_b), .papeis(pap_b), .pronto(pronto_b), .ocupado(ocup_b), .db_seed(seed_b), .db_estado(est_b));
    sorteador_papeis #(.N_JOG(5), .MAX_TENT(1)) u_c (.clock(clock), .reset(reset), .botao(botao), .inicia(inicia_c),
        .papeis(pap_c), .pronto(pronto_c), .ocupado(ocup_c), .db_seed(seed_c), .db_estado(est_c));

    function automatic logic [15:0] passo(input logic [15:0] s);
        return s[0] ? ({1'b0, s[15:1]} ^ 16'hB400) : {1'b0, s[15:1]};
    endfunction

    function automatic logic [1:0] slot(input logic [31:0] p, input int n, input int i);
        return p[2*(n-1-i) +: 2];
    endfunction

    function automatic int conta(input logic [31:0] p, input int n, input logic [1:0] code);
        int c = 0;
        for (int i = 0; i < n; i++) if (slot(p, n, i) == code) c++;
        return c;
    endfunction

    function automatic void modelo(input logic [15:0] seed, input int n, input int nl, input int nm, input int nv,
                                   input int mt, output logic [31:0] pap, output int cyc);
        logic [15:0] s;
        logic [1:0]  code;
        int tent, r, cand, low;
        s = seed; pap = '0; cyc = 0; tent = 0; r = 0;
        while (r < nl + nm + nv) begin
            s = passo(s);
            cyc++;
            code = r < nl ? 2'b01 : r < nl + nm ? 2'b10 : 2'b11;
            cand = int'(s) % (1 << $clog2(n));
            if (tent == mt) begin
                low = 0;
                for (int i = n - 1; i >= 0; i--) if (slot(pap, n, i) == 2'b00) low = i;
                pap[2*(n-1-low) +: 2] = code; r++; tent = 0;
            end else if (cand < n && slot(pap, n, cand) == 2'b00) begin
                pap[2*(n-1-cand) +: 2] = code; r++; tent = 0;
            end else begin
                tent++;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] nl;
        nl = passo(ref_lfsr);
        if (botao && !ref_bq) nl = nl ^ ref_cnt;
        if (nl == 16'h0) nl = 16'h0001;
        if (reset) begin
            ref_lfsr = 16'h0001; ref_cnt = 16'h0; ref_bq = 1'b0;
        end else begin
            ref_lfsr = nl; ref_cnt = ref_cnt + 16'd1; ref_bq = botao;
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic pr(input int w);
        return w == 0 ? pronto_a : w == 1 ? pronto_b : pronto_c;
    endfunction

    function automatic logic [31:0] pp(input int w);
        return w == 0 ? 32'(pap_a) : w == 1 ? 32'(pap_b) : 32'(pap_c);
    endfunction

    // n_left SORTEIA edges remain; pronto must stay low until the last one.
    task automatic espera(input int w, input int n_left, input logic [31:0] exp);
        for (int i = 1; i < n_left; i++) tick();
        chk("pronto_before_done", 32'(pr(w)), 0);
        tick();
        chk("pronto_done", 32'(pr(w)), 1);
        chk("papeis_model", pp(w), exp);
    endtask

    initial begin
        logic [15:0] sd, e, c1, c2;
        logic [31:0] exp;
        int cyc;
        bit ok;
        ref_lfsr = 16'h0001; ref_cnt = 16'h0; ref_bq = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_papeis", 32'(pap_a), 0);
        chk("rst_pronto", 32'(pronto_a), 0);
        chk("rst_estado", 32'(est_a), 0);
        chk("rst_seed", 32'(seed_a), 0);
        chk("rst_ocupado", 32'(ocup_a), 0);
        repeat (9) tick();
        // Default draw
        sd = ref_lfsr; inicia_a = 1'b1; tick(); inicia_a = 1'b0;
        chk("a_ocupado", 32'(ocup_a), 1);
        chk("a_estado", 32'(est_a), 1);
        chk("a_seed", 32'(seed_a), 32'(sd));
        modelo(sd, 5, 1, 1, NV, 15, exp, cyc);
        espera(0, cyc, exp);
        chk("a_n_lobo", conta(32'(pap_a), 5, 2'b01), 1);
        chk("a_n_medico", conta(32'(pap_a), 5, 2'b10), 1);
        chk("a_n_vidente", conta(32'(pap_a), 5, 2'b11), NV);
        chk("a_n_aldeao", conta(32'(pap_a), 5, 2'b00), 3 - NV);
        chk("a_estado_pronto", 32'(est_a), 2);
        repeat (3) tick();
        chk("a_hold_papeis", 32'(pap_a), exp);
        chk("a_hold_pronto", 32'(pronto_a), 1);
        // Two players
        sd = ref_lfsr; inicia_b = 1'b1; tick(); inicia_b = 1'b0;
        modelo(sd, 2, 1, B_MED, NV, 15, exp, cyc);
        espera(1, cyc, exp);
        chk("b_set", 32'(pap_b == 4'b0110 || pap_b == 4'b1001 || pap_b == 4'b0111 || pap_b == 4'b1101), 1);
        chk("b_n_lobo", conta(32'(pap_b), 2, 2'b01), 1);
        // Forced rejection: wait until the first two candidates are out of range
        ok = 1'b0;
        for (int g = 0; g < 2000 && !ok; g++) begin
            c1 = passo(ref_lfsr); c2 = passo(c1);
            ok = c1[2:0] >= 3'd5 && c2[2:0] >= 3'd5;
            if (!ok) tick();
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $error("FAIL rej_search: observed=no_seed expected=seed_found");
        end
        sd = ref_lfsr; inicia_c = 1'b1; tick(); inicia_c = 1'b0;
        modelo(sd, 5, 1, 1, NV, 1, exp, cyc);
        espera(2, cyc, exp);
        chk("c_fallback_p0", 32'(pap_c[9:8]), 32'(2'b01));
        // Restart from PRONTO with inicia held into SORTEIA
        sd = ref_lfsr; inicia_a = 1'b1; tick();
        chk("r_pronto_fall", 32'(pronto_a), 0);
        chk("r_papeis_clear", 32'(pap_a), 0);
        chk("r_ocupado", 32'(ocup_a), 1);
        tick(); inicia_a = 1'b0;
        chk("r_seed_kept", 32'(seed_a), 32'(sd));
        chk("r_still_busy", 32'(ocup_a), 1);
        modelo(sd, 5, 1, 1, NV, 15, exp, cyc);
        espera(0, cyc - 1, exp);
        // Reset during SORTEIA
        inicia_c = 1'b1; tick(); inicia_c = 1'b0;
        chk("m_ocupado", 32'(ocup_c), 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("m_estado", 32'(est_c), 0);
        chk("m_papeis", 32'(pap_c), 0);
        chk("m_ocupado0", 32'(ocup_c), 0);
        chk("m_seed", 32'(seed_c), 0);
        // botao rising edge while the cycle counter holds 16'h0040
        for (int g = 0; g < 200 && ref_cnt != 16'h0040; g++) tick();
        sd = ref_lfsr; botao = 1'b1; tick(); botao = 1'b0;
        e = passo(sd) ^ 16'h0040;
        if (e == 16'h0) e = 16'h0001;
        inicia_a = 1'b1; tick(); inicia_a = 1'b0;
        chk("botao_mix_seed", 32'(seed_a), 32'(e));
        modelo(e, 5, 1, 1, NV, 15, exp, cyc);
        espera(0, cyc, exp);
        chk("botao_n_vidente", conta(32'(pap_a), 5, 2'b11), NV);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
